irq_req_ctrl_8: RTL
===================

# irq_req_ctrl_8

Eight-line interrupt request controller sitting directly upstream of the 8-to-3 priority encoder. It latches raw requests into a pending register, applies a mask and an in-service priority threshold, and presents the eligible request vector to the encoder. It accepts the encoder's 3-bit index back as an acknowledge, tracks nested in-service levels, and retires them on end-of-interrupt. Bit 7 is highest priority throughout, consistent with the encoder.

## Interface
Parameters:
- EDGE, 1: 1 = rising-edge triggered requests; 0 = level triggered.
- RESET_MASK, 8'hFF: mask value loaded at reset (1 = masked).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  8  raw request lines, already synchronous to clk.
- mask_wr  input  1  write strobe for mask register.
- mask_din  input  8  new mask value.
- ack  input  1  acknowledge strobe, one cycle per acknowledge.
- ack_id  input  3  index being acknowledged (encoder output b).
- eoi  input  1  end-of-interrupt strobe.
- req_vec  output  8  eligible requests; drives encoder input a.
- irq_out  output  1  OR of req_vec.
- pending  output  8  pending register.
- in_service  output  8  in-service register.
- mask  output  8  mask register.
- ack_err  output  1  registered one-cycle pulse on a rejected acknowledge.

## Operation
- State: prev_irq[7:0], pending[7:0], in_service[7:0], mask[7:0], ack_err.
- Request capture: EDGE=1 sets pending[i] when irq_in[i]=1 and prev_irq[i]=0; EDGE=0 sets pending[i] whenever irq_in[i]=1. prev_irq loads irq_in every cycle.
- Masked lines still latch into pending; mask only gates req_vec.
- Threshold: let H = index of the highest set bit of in_service. req_vec[i] = pending[i] & ~mask[i] & (i > H). With in_service = 0, every unmasked pending bit is eligible.
- irq_out = |req_vec.
- Acknowledge: ack accepted only when req_vec[ack_id] = 1 (evaluated on current-cycle state). On acceptance, clear pending[ack_id] and set in_service[ack_id]. On rejection, no state change and ack_err = 1 the next cycle.
- EOI: clears the highest set bit of in_service. eoi with in_service = 0 is ignored, with no error.
- Simultaneous events:
  - Set vs ack-clear on the same pending bit: set wins. The new request is retained, and in level mode a still-high line re-pends.
  - ack and eoi in the same cycle: in_service_next = (in_service with highest bit cleared) | accepted ack bit.
  - mask_wr with ack: ack is judged against the old mask; the new mask is effective the next cycle.
- req_vec, irq_out, pending, in_service and mask are combinational or direct register outputs; no further pipeline.

## Timing
- Reset (rst high at a clock edge): pending = 0, in_service = 0, mask = RESET_MASK, ack_err = 0, prev_irq = irq_in. Lines already high at reset exit are therefore not edges in EDGE=1 mode.
- Outputs in the first cycle after reset: req_vec = 0, irq_out = 0.
- Request latency: a rising irq_in sampled at edge N gives pending and req_vec updated after edge N, so irq_out is high in cycle N+1.
- Ack latency: an accepted ack at edge N updates pending, in_service and req_vec after edge N. The encoder sees the new vector the same cycle.
- ack_err is high for exactly the cycle after the rejected ack.
- Reset asserted mid-operation overrides all strobes in that cycle.

## Test plan
- Reset with RESET_MASK = 8'hFF and irq_in = 8'h81 held, EDGE=1 -> pending = 0, req_vec = 0 after reset. Write mask 8'h00, then pulse irq_in[3] -> pending = 8'h08, req_vec = 8'h08, irq_out = 1 one cycle after the edge.
- Nesting: pending bits 2 and 5, ack 5 -> in_service = 8'h20, req_vec = 0. Pulse irq[6] -> req_vec = 8'h40. Ack 6 -> in_service = 8'h60. eoi -> 8'h20. eoi -> 8'h00, req_vec = 8'h04.
- Rejected ack: req_vec = 8'h10, ack_id = 3 -> ack_err pulses one cycle, pending and in_service unchanged.
- Same-cycle new edge on bit 4 with accepted ack 4 -> pending[4] stays 1 and in_service[4] = 1.
- ack 1 and eoi together with in_service = 8'h01 and req_vec = 8'h02 -> in_service = 8'h02.
- EDGE=0: irq_in[0] held high, mask 0, ack 0 -> pending[0] = 1 again next cycle and in_service = 8'h01. Mask bit 0 -> req_vec[0] = 0 while pending[0] = 1.

Source files
------------

// File: rtl/irq_req_ctrl_8.sv
// Eight-line interrupt request controller feeding the 8-to-3 priority encoder.
// Latches requests, applies mask and in-service threshold, and tracks nested service levels.
module irq_req_ctrl_8 #(
    parameter bit         EDGE       = 1'b1,
    parameter logic [7:0] RESET_MASK = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_din,
    input  logic       ack,
    input  logic [2:0] ack_id,
    input  logic       eoi,
    output logic [7:0] req_vec,
    output logic       irq_out,
    output logic [7:0] pending,
    output logic [7:0] in_service,
    output logic [7:0] mask,
    output logic       ack_err
);

    logic [7:0] prev_irq_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] in_service_q, in_service_d;
    logic [7:0] mask_q, mask_d;
    logic       ack_err_q, ack_err_d;

    logic [7:0] above_isr;
    logic [7:0] isr_top;
    logic [7:0] set_vec;
    logic [7:0] ack_vec;
    logic       ack_ok;
    logic       found;

    always_comb begin
        above_isr = '0;
        isr_top   = '0;
        found     = 1'b0;
        // Line i is eligible only when no in-service bit sits at or above i.
        for (int i = 0; i < 8; i++) begin
            above_isr[i] = ~|(in_service_q >> i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (in_service_q[i] && !found) begin
                isr_top[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        set_vec      = EDGE ? (irq_in & ~prev_irq_q) : irq_in;
        req_vec      = pending_q & ~mask_q & above_isr;
        irq_out      = |req_vec;
        ack_ok       = ack & req_vec[ack_id];
        ack_vec      = ack_ok ? (8'b1 << ack_id) : 8'h00;
        // A new request on the acknowledged line survives the clear.
        pending_d    = (pending_q & ~ack_vec) | set_vec;
        in_service_d = (in_service_q & ~(eoi ? isr_top : 8'h00)) | ack_vec;
        mask_d       = mask_wr ? mask_din : mask_q;
        ack_err_d    = ack & ~ack_ok;
    end

    always_ff @(posedge clk) begin
        prev_irq_q <= irq_in;
        if (rst) begin
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= RESET_MASK;
            ack_err_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;
    assign ack_err    = ack_err_q;

endmodule
